// File: rtl/reg_file_ctrl.sv
// Controller owning the write port and read-address ports of a small register file:
// post-reset clear, writeback arbitration and a two-cycle atomic register swap.
// Optional macro SWAP_FAIR_EN: alternate writeback and swap under contention.
module reg_file_ctrl #(
  parameter int DW   = 8,
  parameter int AW   = 2,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_gnt,
  input  logic          swap_req,
  input  logic [AW-1:0] swap_addr_a,
  input  logic [AW-1:0] swap_addr_b,
  output logic          swap_busy,
  output logic          swap_done,
  input  logic [AW-1:0] core_rd_addrA,
  input  logic [AW-1:0] core_rd_addrB,
  output logic          core_rd_stall,
  output logic          init_done,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_dat_in,
  output logic [AW-1:0] rf_rd_addrA,
  output logic [AW-1:0] rf_rd_addrB,
  input  logic [DW-1:0] rf_datA,
  input  logic [DW-1:0] rf_datB
);

  typedef enum logic [1:0] {CLEAR, IDLE, SWAP_A, SWAP_B} state_e;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sa_q, sa_d;
  logic [AW-1:0] sb_q, sb_d;
  logic [DW-1:0] tmp_q, tmp_d;
  logic          init_done_q, init_done_d;
  logic          swap_busy_q, swap_busy_d;
  logic          swap_done_q, swap_done_d;
  logic          swap_owed_q, swap_owed_d;
  logic          wb_win, accept;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sa_d          = sa_q;
    sb_d          = sb_q;
    tmp_d         = tmp_q;
    init_done_d   = init_done_q;
    wb_win        = 1'b0;
    accept        = 1'b0;
    wb_gnt        = 1'b0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = wb_addr;
    rf_dat_in     = wb_data;
    rf_rd_addrA   = core_rd_addrA;
    rf_rd_addrB   = core_rd_addrB;
    core_rd_stall = 1'b0;

    case (state_q)
      CLEAR: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = cnt_q;
        rf_dat_in  = '0;
        cnt_d      = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        // An owed swap beats writeback once; otherwise writeback has priority.
        wb_win = wb_req && !(swap_owed_q && swap_req);
        if (wb_win) begin
          wb_gnt   = 1'b1;
          rf_wr_en = 1'b1;
        end else if (swap_req) begin
          accept  = 1'b1;
          sa_d    = swap_addr_a;
          sb_d    = swap_addr_b;
          state_d = SWAP_A;
        end
      end
      SWAP_A: begin
        rf_rd_addrA   = sa_q;
        rf_rd_addrB   = sb_q;
        core_rd_stall = 1'b1;
        rf_wr_en      = 1'b1;
        rf_wr_addr    = sa_q;
        rf_dat_in     = rf_datB;
        tmp_d         = rf_datA;
        state_d       = SWAP_B;
      end
      SWAP_B: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = sb_q;
        rf_dat_in  = tmp_q;
        state_d    = IDLE;
      end
      default: state_d = CLEAR;
    endcase

    // Hold the register file quiet while reset is asserted, whatever state_q says.
    if (!rst_n) begin
      rf_wr_en      = 1'b0;
      wb_gnt        = 1'b0;
      core_rd_stall = 1'b0;
    end

    swap_busy_d = (state_d == SWAP_A) || (state_d == SWAP_B);
    swap_done_d = (state_q == SWAP_B);

`ifdef SWAP_FAIR_EN
    swap_owed_d = swap_owed_q;
    if (accept)                   swap_owed_d = 1'b0;
    else if (wb_gnt && swap_req)  swap_owed_d = 1'b1;
`else
    swap_owed_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      tmp_q       <= '0;
      init_done_q <= 1'b0;
      swap_busy_q <= 1'b0;
      swap_done_q <= 1'b0;
      swap_owed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      tmp_q       <= tmp_d;
      init_done_q <= init_done_d;
      swap_busy_q <= swap_busy_d;
      swap_done_q <= swap_done_d;
      swap_owed_q <= swap_owed_d;
    end
  end

  assign init_done = init_done_q;
  assign swap_busy = swap_busy_q;
  assign swap_done = swap_done_q;

endmodule
